gate2_checker: RTL and testbench
================================

# gate2_checker

Hardware exhaustive checker for any 2-input combinational gate on the board. It drives the gate inputs through all four input combinations, holds each one for a programmable dwell, samples the gate output, and compares the captured truth table against an expected one. Pass/fail and mismatch bits go to LEDs. It is the synthesizable counterpart of the per-gate simulation stimulus: it sits between the top-level pins/LEDs and the gate under test (or2, and2, xor2, ...).

## Interface
Parameters:
- `DWELL`, default 12000000: clock cycles each input vector is held (1 s at 12 MHz); legal range ≥ 4.
- `EXPECTED`, default 4'b1110 (OR): expected z0 for vector index v = {x0,x1}; bit v = output for that vector.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle start pulse, already debounced and edge-detected upstream.
- `z0` in 1: output of the gate under test; may be asynchronous.
- `x0` out 1: gate input 0, MSB of the vector index.
- `x1` out 1: gate input 1, LSB of the vector index.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; results valid.
- `pass` out 1: captured table == EXPECTED; valid only while done=1, 0 otherwise.
- `result` out 4: captured truth table; bit v = sampled z0 for vector v.
- `mismatch` out 4: result ^ EXPECTED while done=1, 0 otherwise.

## Operation
- z0 passes through a 2-flop synchronizer (z0_s) before any use.
- FSM states are IDLE, RUN and DONE. A 2-bit vector index `vec` and a dwell counter `cnt` (width $clog2(DWELL)) run alongside.
- **IDLE**: x0=x1=0, busy=0, done=0. A start pulse clears `result`, sets vec=0 and cnt=0, and moves to RUN.
- **RUN**:
  - {x0,x1}=vec, busy=1, cnt increments each cycle.
  - When cnt==DWELL-1: result[vec] ← z0_s and cnt ← 0.
  - If vec==3 the FSM moves to DONE; otherwise vec increments.
  - Vector order is 00, 01, 10, 11.
- **DONE**: done=1, busy=0, x0=x1=0, and pass/mismatch are driven. The FSM holds until the next start pulse, which behaves exactly as start from IDLE (results cleared, done drops).
- start is ignored in RUN.
- Reset in any state (including mid-sweep) returns to IDLE and clears every register, including the synchronizer flops.
- Because z0_s lags z0 by 2 cycles, the sample at cnt==DWELL-1 reflects z0 at dwell cycle DWELL-3. DWELL ≥ 4 guarantees the sampled value belongs to the current vector and not the previous one. Glitches earlier in the dwell are not captured.

## Timing
- Reset values: x0=0, x1=0, busy=0, done=0, pass=0, result=0000, mismatch=0000.
- Start registered at edge T0: vector 00 is driven and busy=1 from T0+1.
- Vector k is driven for cycles T0+1+k·DWELL through T0+(k+1)·DWELL.
- done=1 and busy=0 from T0+4·DWELL+1. Total sweep latency is 4·DWELL+1 cycles.
- pass and mismatch become valid in the same cycle as done, with no extra cycle of delay.
- All outputs are registered or decoded only from registered state, so there are no combinational paths from inputs to outputs.

## Structure
- Shared include `gate2_pkg.vh`:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NUM_VEC=4.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- One sub-module, `sync2`: 2-flop synchronizer with clk and rstn, reset value 0, used for z0.
- The FSM, counter and compare logic stay in gate2_checker.
- The board top instantiates gate2_checker with the gate under test and maps pass/fail/result to LEDs.

## Test plan
Bench runs with DWELL=4.
- **Reset**: assert rstn=0 for 2 cycles with z0=1 and start=0 → all outputs at their reset values. Release → outputs unchanged.
- **OR pass**: or2 wired as DUT, EXPECTED=4'b1110, start pulse at T0 → x0x1 = 00/01/10/11 over cycles T0+1..4, 5..8, 9..12, 13..16. At T0+17: done=1, result=1110, pass=1, mismatch=0000.
- **Fail detect**: and2 wired as DUT, EXPECTED=TT_OR → result=1000, mismatch=0110, pass=0, done=1.
- **Start handling**: a pulse during RUN at vector 01 leaves timing unchanged (done still at T0+17). A pulse in DONE clears done and result next cycle and repeats the sweep.
- **Mid-sweep reset**: rstn=0 for one cycle while vector 10 is driven → next cycle x0=x1=0, busy=0, result=0000. A following start runs a full, correct sweep.
- **Sampling window**: DUT model replaced by a driver giving z0=0 for 1 cycle then 1 on every vector; with EXPECTED=1111 → pass=1, so the early value is not captured.

Source files
------------

// File: rtl/gate2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate2_pkg
//  Description : Shared definitions for the 2-input gate checker: FSM state
//                encodings, vector count and the standard truth tables.
//                Truth-table bit v is the gate output for vector v={x0,x1}.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/gate2_checker_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous bit.
//  Ports       : clk  - system clock
//                rstn - synchronous active-low reset, clears both flops
//                d    - asynchronous input
//                q    - synchronized output (2-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gate2_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate2_checker
//  Description : Exhaustive checker for a 2-input combinational gate. Sweeps
//                {x0,x1} through 00,01,10,11, holding each for DWELL cycles,
//                samples the synchronized gate output at the end of each
//                dwell and compares the captured table with EXPECTED.
//  Ports       : clk, rstn (sync, active-low), start (1-cycle pulse),
//                z0 (gate output, async) -> x0/x1 (gate inputs), busy, done,
//                pass, result[3:0], mismatch[3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module gate2_checker
    import gate2_pkg::*;
#(
    parameter int         DWELL    = 12000000,
    parameter logic [3:0] EXPECTED = 4'b1110
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       z0,
    output logic       x0,
    output logic       x1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [3:0] mismatch
);

    localparam int             CNT_W      = $clog2(DWELL);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [1:0]     C_VEC_LAST = 2'(NUM_VEC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_vec;
    logic [1:0]       w_vec_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_result;
    logic [3:0]       w_result_nxt;
    logic             w_z0_s;

    sync2 u_sync_z0 (
        .clk  (clk),
        .rstn (rstn),
        .d    (z0),
        .q    (w_z0_s)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_vec    <= 2'd0;
            r_cnt    <= '0;
            r_result <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_vec    <= w_vec_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_vec_nxt    = r_vec;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        case (r_state)
            // A restart from DONE behaves exactly like a start from IDLE.
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt  = RUN;
                    w_vec_nxt    = 2'd0;
                    w_cnt_nxt    = '0;
                    w_result_nxt = 4'd0;
                end
            end
            RUN: begin
                // z0_s lags z0 by two cycles, so this sample reflects the
                // gate output well after the current vector has settled.
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt           = '0;
                    w_result_nxt[r_vec] = w_z0_s;
                    if (r_vec == C_VEC_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_vec_nxt = r_vec + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only; no input-to-output paths.
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign x0       = busy & r_vec[1];
    assign x1       = busy & r_vec[0];
    assign result   = r_result;
    assign pass     = done & (r_result == EXPECTED);
    assign mismatch = done ? (r_result ^ EXPECTED) : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_gate2_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gate2_checker
//  Description : Testbench for gate2_checker with DWELL=4. Instance dut_or
//                expects OR and is driven by an OR or AND gate model;
//                instance dut_win expects 1111 and is driven by a model that
//                outputs 0 for the first cycle of every vector, then 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate2_checker;
    import gate2_pkg::*;

    localparam int DW = 4;

    typedef struct packed {
        logic [3:0] result;
        logic [3:0] mismatch;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;

    // gate model select for dut_or: 0 = or2, 1 = and2; force_one overrides
    logic gate_and = 1'b0;
    logic force_one = 1'b0;

    logic       z0_a, x0_a, x1_a, busy_a, done_a, pass_a;
    logic [3:0] result_a, mismatch_a;
    logic       z0_b, x0_b, x1_b, busy_b, done_b, pass_b;
    logic [3:0] result_b, mismatch_b;

    logic [2:0] r_prev_key_b = 3'b000;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    assign z0_a = force_one ? 1'b1 : (gate_and ? (x0_a & x1_a) : (x0_a | x1_a));

    // 0 during the first cycle after {busy,x0,x1} changes, else 1
    always @(posedge clk) r_prev_key_b <= {busy_b, x0_b, x1_b};
    assign z0_b = ({busy_b, x0_b, x1_b} == r_prev_key_b);

    gate2_checker #(.DWELL(DW), .EXPECTED(TT_OR)) dut_or (
        .clk(clk), .rstn(rstn), .start(start), .z0(z0_a),
        .x0(x0_a), .x1(x1_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .result(result_a), .mismatch(mismatch_a)
    );

    gate2_checker #(.DWELL(DW), .EXPECTED(4'b1111)) dut_win (
        .clk(clk), .rstn(rstn), .start(start), .z0(z0_b),
        .x0(x0_b), .x1(x1_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .result(result_b), .mismatch(mismatch_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on each rising done, pop the expected record and compare.
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;
    always @(posedge clk) begin
        #1;
        if (done_a && !prev_done_a) begin
            if (q_a.size() == 0) begin
                check("sb_or_unexpected_done", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("sb_or_result", 16'(result_a), 16'(e.result));
                check("sb_or_mismatch", 16'(mismatch_a), 16'(e.mismatch));
                check("sb_or_pass", 16'(pass_a), 16'(e.pass));
            end
        end
        if (done_b && !prev_done_b) begin
            if (q_b.size() == 0) begin
                check("sb_win_unexpected_done", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("sb_win_result", 16'(result_b), 16'(e.result));
                check("sb_win_mismatch", 16'(mismatch_b), 16'(e.mismatch));
                check("sb_win_pass", 16'(pass_b), 16'(e.pass));
            end
        end
        prev_done_a = done_a;
        prev_done_b = done_b;
    end

    // Full sweep from a start pulse; checks vector order, timing and done
    // latency. Optionally injects a start pulse during vector 01.
    task automatic run_sweep(input exp_t ea, input logic inject);
        exp_t eb;
        eb.result = 4'b1111; eb.mismatch = 4'b0000; eb.pass = 1'b1;
        q_a.push_back(ea);
        q_b.push_back(eb);
        start = 1'b1;
        tick();                         // edge T0 registered start
        start = 1'b0;
        check("t1_done_cleared", 16'(done_a), 16'd0);
        check("t1_result_cleared", 16'(result_a), 16'd0);
        for (int n = 1; n <= 4 * DW; n++) begin
            check("sweep_busy", 16'(busy_a), 16'd1);
            check("sweep_vec", 16'({x0_a, x1_a}), 16'((n - 1) / DW));
            start = (inject && n == DW + 2);
            tick();
            start = 1'b0;
        end
        // cycle T0+17
        check("done_at_17", 16'(done_a), 16'd1);
        check("busy_at_17", 16'(busy_a), 16'd0);
        check("x_at_17", 16'({x0_a, x1_a}), 16'd0);
        check("win_done_at_17", 16'(done_b), 16'd1);
        tick();
        tick();
        check("done_holds", 16'(done_a), 16'd1);
    endtask

    initial begin
        exp_t e_or, e_and;
        e_or.result  = 4'b1110; e_or.mismatch  = 4'b0000; e_or.pass  = 1'b1;
        e_and.result = 4'b1000; e_and.mismatch = 4'b0110; e_and.pass = 1'b0;

        // Reset with z0 forced high
        force_one = 1'b1;
        rstn = 1'b0;
        #1;
        tick();
        tick();
        check("rst_outputs", 16'({x0_a, x1_a, busy_a, done_a, pass_a, result_a, mismatch_a}), 16'd0);
        rstn = 1'b1;
        tick();
        check("rst_release_outputs", 16'({x0_a, x1_a, busy_a, done_a, pass_a, result_a, mismatch_a}), 16'd0);
        tick();
        check("idle_no_start", 16'({busy_a, done_a}), 16'd0);
        force_one = 1'b0;
        tick();
        tick();

        // OR pass
        gate_and = 1'b0;
        run_sweep(e_or, 1'b0);

        // Restart from DONE with an AND gate: fail detection
        gate_and = 1'b1;
        run_sweep(e_and, 1'b0);

        // Start during RUN at vector 01 must not disturb timing
        gate_and = 1'b0;
        run_sweep(e_or, 1'b1);

        // Mid-sweep reset during vector 10
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 2 * DW; n++) tick();
        check("mid_vec10", 16'({x0_a, x1_a}), 16'b10);
        check("mid_partial_result", 16'(result_a), 16'b0010);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_x", 16'({x0_a, x1_a}), 16'd0);
        check("mid_rst_busy", 16'(busy_a), 16'd0);
        check("mid_rst_result", 16'(result_a), 16'd0);
        check("mid_rst_done", 16'(done_a), 16'd0);
        tick();
        tick();
        run_sweep(e_or, 1'b0);

        tick();
        tick();
        check("sb_or_drained", 16'(q_a.size()), 16'd0);
        check("sb_win_drained", 16'(q_b.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (limit 200000 ns)");
        $fatal(1);
    end

endmodule
`default_nettype wire
